// File: rtl/lfa_pkg.sv
// ---------------------------------------------------------------------------
// lfa_pkg
// Shared definitions for the line-follower ADC reader:
//   - FSM state encoding for the SPI frame sequencer
//   - sensor channel indices LEFT / MID / RIGHT
//   - ADC128S022 bit positions within a 16-bit SPI frame
//   - helpers: channel rotation, address bit lookup, first-order filter step
// ---------------------------------------------------------------------------
package lfa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    LEFT,
    MID,
    RIGHT
  } ch_t;

  localparam int         FRAME_BITS   = 16;
  localparam logic [3:0] ADDR_K_FIRST = 4'd2;
  localparam logic [3:0] DATA_K_FIRST = 4'd4;
  localparam logic [3:0] LAST_K       = 4'(FRAME_BITS - 1);

  // Round-robin scan order: LEFT -> MID -> RIGHT -> LEFT.
  function automatic ch_t next_ch(input ch_t ch);
    case (ch)
      LEFT:    return MID;
      MID:     return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  // DIN value for bit k: ADD2..ADD0 occupy three consecutive bits starting at
  // ADDR_K_FIRST. For k below ADDR_K_FIRST the subtraction wraps to a large
  // value and falls into the default.
  function automatic logic addr_bit(input logic [3:0] k, input logic [2:0] addr);
    logic [3:0] off;
    off = k - ADDR_K_FIRST;
    case (off)
      4'd0:    return addr[2];
      4'd1:    return addr[1];
      4'd2:    return addr[0];
      default: return 1'b0;
    endcase
  endfunction

  // out + ((new - out) >>> 2) with a signed 13-bit difference. The step never
  // overshoots the new sample, so the result stays within 0..4095.
  function automatic logic [11:0] avg_step(input logic [11:0] cur, input logic [11:0] smp);
    logic signed [12:0] diff;
    logic signed [12:0] step;
    logic signed [12:0] sum;
    diff = $signed({1'b0, smp}) - $signed({1'b0, cur});
    step = diff >>> 2;
    sum  = $signed({1'b0, cur}) + step;
    return sum[11:0];
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// ---------------------------------------------------------------------------
// adc_sclk_gen
// Half-period counter that produces the SPI clock and one-cycle strobes that
// flag the clock on which sck will fall or rise.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   run      in   1 = count and toggle; 0 = hold counter at 0 with sck high
//   sck      out  SPI clock, idles high
//   sck_fall out  sck goes low on this clock edge
//   sck_rise out  sck goes high on this clock edge
// ---------------------------------------------------------------------------
module adc_sclk_gen #(
  parameter int HALF = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic sck_fall,
  output logic sck_rise
);

  localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q;
  logic          sck_q;

  // Each half period lasts HALF clocks; sck toggles at the end of it.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt_q <= '0;
      sck_q <= 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The strobes are not gated by run directly (the FSM derives run from
  // sck_fall); while stopped the counter sits at 0, which never equals LAST
  // because HALF >= 2, so no strobe can fire.
  assign sck      = sck_q;
  assign sck_fall = (cnt_q == LAST) && sck_q;
  assign sck_rise = (cnt_q == LAST) && !sck_q;

endmodule

// File: rtl/lfa_adc_reader.sv
// ---------------------------------------------------------------------------
// lfa_adc_reader
// SPI initiator for the ADC128S022. Scans the left, middle and right
// line-follower sensors round-robin and holds the latest 12-bit conversion of
// each in a register.
// Ports:
//   clk_50M       in   system clock
//   reset         in   synchronous active-high reset
//   enable        in   1 = scan continuously, 0 = stop after current frame
//   adc_cs_n      out  ADC chip select, active low
//   adc_sck       out  SPI clock, idles high
//   adc_din       out  ADC DIN (channel address bits)
//   adc_dout      in   ADC DOUT (conversion bits)
//   left          out  latest left-sensor conversion
//   middle        out  latest middle-sensor conversion
//   right         out  latest right-sensor conversion
//   sample_valid  out  one-cycle pulse when the triplet has been refreshed
// Build option:
//   LFA_AVG_EN  when defined, each output is a first-order low-pass filter of
//               the samples; otherwise each output is the raw sample.
// ---------------------------------------------------------------------------
module lfa_adc_reader
  import lfa_pkg::*;
#(
  parameter int CLK_DIV  = 16,
  parameter int CH_LEFT  = 3,
  parameter int CH_MID   = 2,
  parameter int CH_RIGHT = 1
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] left,
  output logic [11:0] middle,
  output logic [11:0] right,
  output logic        sample_valid
);

  localparam int               H        = CLK_DIV / 2;
  localparam int               GAP_CLKS = 2 * H;
  localparam int               GAP_W    = $clog2(GAP_CLKS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  state_t             state_q, state_d;
  logic               run;
  logic               sck_fall, sck_rise;
  logic               last_fall;
  logic               cs_n_q;
  logic               din_q;
  logic [3:0]         bit_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  ch_t                ch_q;
  ch_t                data_ch_q;
  logic               discard_q;
  logic               update_q;
  logic [11:0]        shift_q;
  logic [2:0]         cur_addr;
  logic [11:0]        wr_val;
  logic [11:0]        left_q, middle_q, right_q;
  logic               sample_valid_q;
`ifdef LFA_AVG_EN
  logic [2:0]         loaded_q;
  logic [11:0]        cur_out;
`endif

  adc_sclk_gen #(
    .HALF (H)
  ) u_sclk (
    .clk      (clk_50M),
    .reset    (reset),
    .run      (run),
    .sck      (adc_sck),
    .sck_fall (sck_fall),
    .sck_rise (sck_rise)
  );

  // The falling-edge slot after the k=15 high phase ends the shift: sck is
  // held high instead of falling, and the frame moves on to GAP.
  assign last_fall = (state_q == SHIFT) && sck_fall && (bit_cnt_q == LAST_K);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cs_n_q  <= !((state_d == SETUP) || (state_d == SHIFT));
    end
  end

  // SETUP ends on the first sck fall (bit 0); GAP re-arms or parks in IDLE.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = SETUP;
      end
      SETUP: begin
        run = 1'b1;
        if (sck_fall) state_d = SHIFT;
      end
      SHIFT: begin
        run = !last_fall;
        if (last_fall) state_d = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = enable ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_addr = 3'(CH_LEFT);
    case (ch_q)
      MID:     cur_addr = 3'(CH_MID);
      RIGHT:   cur_addr = 3'(CH_RIGHT);
      default: ;
    endcase
  end

  // Frame datapath. Data shifted in during a frame belongs to the channel
  // addressed in the previous frame (data_ch_q); the frame pointer advances
  // when the shift ends, which also clears the discard flag.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ch_q      <= LEFT;
      data_ch_q <= LEFT;
      discard_q <= 1'b1;
      update_q  <= 1'b0;
      shift_q   <= '0;
      din_q     <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if ((state_q == SETUP) && sck_fall) begin
        bit_cnt_q <= '0;
        din_q     <= 1'b0;
      end
      if (state_q == SHIFT) begin
        if (sck_rise) begin
          if (bit_cnt_q >= DATA_K_FIRST) shift_q <= {shift_q[10:0], adc_dout};
          if (bit_cnt_q == LAST_K) update_q <= 1'b1;
        end
        if (last_fall) begin
          din_q     <= 1'b0;
          gap_cnt_q <= '0;
          data_ch_q <= ch_q;
          ch_q      <= next_ch(ch_q);
          discard_q <= 1'b0;
        end else if (sck_fall) begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          din_q     <= addr_bit(bit_cnt_q + 4'd1, cur_addr);
        end
      end
      if (state_q == GAP) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
        if (state_d == IDLE) begin
          ch_q      <= LEFT;
          discard_q <= 1'b1;
        end
      end
    end
  end

`ifdef LFA_AVG_EN
  // The first sample of each channel after reset loads directly; later
  // samples are blended into the running value.
  always_comb begin
    cur_out = left_q;
    case (data_ch_q)
      MID:     cur_out = middle_q;
      RIGHT:   cur_out = right_q;
      default: ;
    endcase
    wr_val = loaded_q[data_ch_q] ? avg_step(cur_out, shift_q) : shift_q;
  end
`else
  assign wr_val = shift_q;
`endif

  // Result registers, written on the clock after the k=15 sample unless the
  // frame is a pipeline-fill frame.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      left_q         <= '0;
      middle_q       <= '0;
      right_q        <= '0;
      sample_valid_q <= 1'b0;
`ifdef LFA_AVG_EN
      loaded_q       <= '0;
`endif
    end else begin
      sample_valid_q <= 1'b0;
      if (update_q && !discard_q) begin
        case (data_ch_q)
          LEFT:  left_q   <= wr_val;
          MID:   middle_q <= wr_val;
          RIGHT: begin
            right_q        <= wr_val;
            sample_valid_q <= 1'b1;
          end
          default: ;
        endcase
`ifdef LFA_AVG_EN
        loaded_q[data_ch_q] <= 1'b1;
`endif
      end
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_din      = din_q;
  assign left         = left_q;
  assign middle       = middle_q;
  assign right        = right_q;
  assign sample_valid = sample_valid_q;

endmodule
